// File: rtl/bits2bytes_stream.sv
// Streaming bit packer: gathers IN_W-bit fields LSB-first and emits N_BYTES-wide
// words. The final partial word is zero-padded and tagged with out_last/out_nbytes.
module bits2bytes_stream #(
  parameter int IN_W    = 12,
  parameter int N_BYTES = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN_W-1:0]                in_bits,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_BYTES-1:0][7:0]        out_bytes,
  output logic                           out_last,
  output logic [$clog2(N_BYTES+1)-1:0]   out_nbytes
);

  localparam int OUT_W = 8 * N_BYTES;
  localparam int ACC_W = OUT_W + IN_W;
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int NBW   = $clog2(N_BYTES + 1);
  localparam logic [FW-1:0] OUT_W_F = FW'(OUT_W);
  localparam logic [FW-1:0] IN_W_F  = FW'(IN_W);

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_word_q, out_word_d;
  logic               out_last_q, out_last_d;
  logic [NBW-1:0]     out_nbytes_q, out_nbytes_d;

  logic               slot_free;
  logic               load;
  logic               in_fire;
  logic               final_word;
  logic [FW-1:0]      take;
  logic [FW-1:0]      fill_base;
  logic [FW:0]        take_rnd;
  logic [ACC_W-1:0]   acc_shift;
  logic [OUT_W-1:0]   keep_mask;

  // Word load decision, accumulator shift/insert and next-state logic.
  always_comb begin
    slot_free  = !out_valid_q || out_ready;
    take       = (fill_q >= OUT_W_F) ? OUT_W_F : fill_q;
    final_word = (state_q == FLUSH) && (fill_q <= OUT_W_F);
    load       = slot_free && ((fill_q >= OUT_W_F) ||
                               ((state_q == FLUSH) && (fill_q != {FW{1'b0}})));
    // Readiness depends only on registered state, never on out_ready.
    in_ready   = (state_q == ACCUM) && (fill_q <= OUT_W_F);
    in_fire    = in_valid && in_ready;
    keep_mask  = ~({OUT_W{1'b1}} << take);
    take_rnd   = {1'b0, take} + (FW+1)'(7);

    if (load) begin
      acc_shift = acc_q >> take;
      fill_base = fill_q - take;
    end else begin
      acc_shift = acc_q;
      fill_base = fill_q;
    end

    acc_d        = acc_shift;
    fill_d       = fill_base;
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_last_d   = out_last_q;
    out_nbytes_d = out_nbytes_q;

    if (in_fire) begin
      acc_d  = acc_shift | (ACC_W'(in_bits) << fill_base);
      fill_d = fill_base + IN_W_F;
    end else begin
      acc_d  = acc_shift;
      fill_d = fill_base;
    end

    if (load) begin
      out_word_d   = acc_q[OUT_W-1:0] & keep_mask;
      out_valid_d  = 1'b1;
      out_nbytes_d = NBW'(take_rnd >> 3);
      out_last_d   = final_word;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ACCUM: begin
        if (in_fire && in_last) begin
          state_d = FLUSH;
        end else begin
          state_d = ACCUM;
        end
      end
      FLUSH: begin
        if (load && final_word) begin
          state_d = ACCUM;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= {ACC_W{1'b0}};
      fill_q       <= {FW{1'b0}};
      out_valid_q  <= 1'b0;
      out_word_q   <= {OUT_W{1'b0}};
      out_last_q   <= 1'b0;
      out_nbytes_q <= {NBW{1'b0}};
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_last_q   <= out_last_d;
      out_nbytes_q <= out_nbytes_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bytes  = out_word_q;
  assign out_last   = out_last_q;
  assign out_nbytes = out_nbytes_q;

endmodule

// File: tb/tb_bits2bytes_stream.sv
// Bench for bits2bytes_stream: directed cases plus random streams checked against
// a bit-queue packing model; every output word is compared while valid.
module tb_bits2bytes_stream;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [11:0]      in_bits;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [3:0][7:0]  out_bytes;
  logic             out_last;
  logic [2:0]       out_nbytes;

  typedef struct {
    logic [31:0] word;
    logic        last;
    int          nb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;
  bit   mon_en   = 1'b1;
  bit   bp_seen  = 1'b0;
  int   bp_cnt   = 0;
  logic [11:0] beats[64];

  bits2bytes_stream #(.IN_W(12), .N_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
    .out_last(out_last), .out_nbytes(out_nbytes)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic l, input int nb);
    exp_t e;
    e.word = w; e.last = l; e.nb = nb;
    exp_q.push_back(e);
  endtask

  // Reference: flatten all beats into one bit list, then cut into 32-bit words.
  task automatic model_stream(input int n);
    bit bits[$];
    int total, nw, rem;
    logic [31:0] w;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 12; b++) bits.push_back(beats[i][b]);
    total = bits.size();
    nw = (total + 31) / 32;
    for (int k = 0; k < nw; k++) begin
      w = 32'h0;
      for (int j = 0; j < 32; j++)
        if (k * 32 + j < total) w[j] = bits[k * 32 + j];
      rem = total - k * 32;
      if (k == nw - 1) push_exp(w, 1'b1, (rem > 32) ? 4 : (rem + 7) / 8);
      else             push_exp(w, 1'b0, 4);
    end
  endtask

  // Called and returns at posedge+1; holds the beat until accepted.
  task automatic send_beat(input logic [11:0] b, input logic last, input bit gaps);
    int t;
    bit done;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_bits = b; in_last = last;
    t = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else if (++t > 2000) begin chk("in_ready_timeout", 64'd0, 64'd1); done = 1'b1; end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_stream(input int n, input bit gaps);
    for (int i = 0; i < n; i++) send_beat(beats[i], (i == n - 1), gaps);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_after_stream", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_case1();
    for (int i = 0; i < 8; i++) beats[i] = 12'(i + 1);
    push_exp(32'h03002001, 1'b0, 4);
    push_exp(32'h60050040, 1'b0, 4);
    push_exp(32'h00800700, 1'b1, 4);
  endtask

  // Output scoreboard: the head word must be presented intact while valid.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 64'd1, 64'd0);
        end else begin
          chk("word", 64'(out_bytes), 64'(exp_q[0].word));
          chk("last", 64'(out_last), 64'(exp_q[0].last));
          chk("nbytes", 64'(out_nbytes), 64'(exp_q[0].nb));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // out_ready patterns: 0 always ready, 1 random, 2 stall-then-toggle, else held low.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom);
        2: begin
          if (!bp_seen) begin
            if (out_valid) begin bp_seen = 1'b1; bp_cnt = 0; out_ready = 1'b0; end
            else out_ready = 1'b1;
          end else begin
            bp_cnt++;
            if (bp_cnt < 10) out_ready = 1'b0;
            else out_ready = ~out_ready;
            if (bp_cnt == 9) begin
              @(negedge clk);
              chk("bp_in_ready", 64'(in_ready), 64'd0);
            end
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_bits = 12'h0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_bytes", 64'(out_bytes), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Directed stream, always ready.
    push_case1();
    send_stream(8, 1'b0);
    wait_drain();

    // Partial tail: input stays blocked until the final word loads.
    for (int i = 0; i < 3; i++) beats[i] = 12'hFFF;
    push_exp(32'hFFFFFFFF, 1'b0, 4);
    push_exp(32'h0000000F, 1'b1, 1);
    send_stream(3, 1'b0);
    @(negedge clk);
    chk("tail_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    wait_drain();

    // Single beat.
    beats[0] = 12'hABC;
    push_exp(32'h00000ABC, 1'b1, 2);
    send_stream(1, 1'b0);
    wait_drain();

    // Backpressure.
    bp_seen = 1'b0; rdy_mode = 2;
    push_case1();
    send_stream(8, 1'b0);
    wait_drain();
    rdy_mode = 0;

    // Reset mid-stream with output blocked, then replay.
    mon_en = 1'b0; rdy_mode = 3;
    for (int i = 0; i < 5; i++) send_beat(12'(i + 1), 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_bytes", 64'(out_bytes), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_out_nbytes", 64'(out_nbytes), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; rdy_mode = 0; mon_en = 1'b1;
    @(posedge clk); #1;
    push_case1();
    send_stream(8, 1'b0);
    wait_drain();

    // Random streams with random gaps and backpressure.
    rdy_mode = 1;
    for (int s = 0; s < 200; s++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) beats[i] = 12'($urandom);
      model_stream(n);
      send_stream(n, 1'b1);
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
